picoblaze_port_hub: RTL and testbench

Parametrised port-mapped I/O hub between the KCPSM6 processor and peripherals (RTC port, VGA/keyboard, display registers). Replaces hand-written input muxes and single output registers with N_OUT write registers, N_IN registered read channels with read-acknowledge pulses, and a maskable edge-triggered interrupt controller driving the processor's interrupt input.

---
 rtl/picoblaze_port_hub.sv | 218 +++++++++++++++++++++
 tb/tb_picoblaze_port_hub.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/picoblaze_port_hub.sv
// picoblaze_port_hub
// Port-mapped I/O hub between a KCPSM6 processor and its peripherals.
//   - N_OUT write registers at port IDs OUT_BASE..OUT_BASE+N_OUT-1, each
//     with a one-cycle wr_pulse flag after an update.
//   - N_IN read channels (IDs in IN_IDS) muxed into a registered in_port,
//     with a one-cycle rd_pulse acknowledge to the channel that was read.
//   - N_IRQ edge-triggered interrupt sources with a pending register
//     (read at IRQ_STAT_ID, write-1-to-clear) and an enable mask
//     (read/write at IRQ_MASK_ID), driving a registered interrupt output.
// Optional build macro: K_WRITE_EN -- when defined, OUTPUTK (k_write_strobe)
//   may also write output registers whose ID is below 16, matched on
//   port_id[3:0]. When undefined, k_write_strobe is ignored.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   port_id, out_port     processor address / write data
//   write_strobe          OUTPUT strobe
//   k_write_strobe        OUTPUTK strobe
//   read_strobe           INPUT strobe
//   in_data               peripheral read data, channel i at [8i+7:8i]
//   in_port               registered read data to processor
//   rd_pulse              per-channel read acknowledge
//   out_regs, wr_pulse    output register contents / update flags
//   irq_src, interrupt    raw interrupt sources / request to processor
module picoblaze_port_hub #(
  parameter int                N_OUT       = 9,
  parameter logic [7:0]        OUT_BASE    = 8'd2,
  parameter logic [7:0]        OUT_RST     = 8'h00,
  parameter int                N_IN        = 4,
  parameter logic [8*N_IN-1:0] IN_IDS      = {8'd15, 8'd13, 8'd12, 8'd3},
  parameter int                N_IRQ       = 2,
  parameter logic [N_IRQ-1:0]  IRQ_ACT_LOW = 2'b01,
  parameter logic [7:0]        IRQ_STAT_ID = 8'd20,
  parameter logic [7:0]        IRQ_MASK_ID = 8'd21
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          port_id,
  input  logic [7:0]          out_port,
  input  logic                write_strobe,
  input  logic                k_write_strobe,
  input  logic                read_strobe,
  input  logic [8*N_IN-1:0]   in_data,
  output logic [7:0]          in_port,
  output logic [N_IN-1:0]     rd_pulse,
  output logic [8*N_OUT-1:0]  out_regs,
  output logic [N_OUT-1:0]    wr_pulse,
  input  logic [N_IRQ-1:0]    irq_src,
  output logic                interrupt
);

  // Port ID of output register k (8-bit wraparound, as the processor sees it).
  function automatic logic [7:0] out_id(input int k);
    return OUT_BASE + 8'(k);
  endfunction

`ifdef K_WRITE_EN
  // OUTPUTK only carries a 4-bit port address, so only registers below 16
  // are reachable, matched on the low nibble.
  function automatic logic k_reachable(input int k);
    return (int'(OUT_BASE) + k) < 16;
  endfunction

  function automatic logic [3:0] out_nib(input int k);
    logic [7:0] id;
    id = OUT_BASE + 8'(k);
    return id[3:0];
  endfunction
`else
  logic w_unused_k;
  assign w_unused_k = k_write_strobe;
`endif

  logic [8*N_OUT-1:0] r_out;
  logic [N_OUT-1:0]   r_wr_pulse;
  logic [7:0]         r_in_port;
  logic [N_IN-1:0]    r_rd_pulse;
  logic [N_IRQ-1:0]   r_sync1;
  logic [N_IRQ-1:0]   r_sync2;
  logic [N_IRQ-1:0]   r_prev;
  logic [N_IRQ-1:0]   r_pending;
  logic [N_IRQ-1:0]   r_mask;
  logic               r_irq;

  logic [N_OUT-1:0]   w_wr_hit;
  logic               w_mask_wr;
  logic [N_IRQ-1:0]   w_clr_bits;
  logic [N_IRQ-1:0]   w_edge;
  logic [N_IRQ-1:0]   w_pend_nxt;
  logic [7:0]         w_pend_pad;
  logic [7:0]         w_mask_pad;
  logic [7:0]         w_rd_data;
  logic [N_IN-1:0]    w_rd_sel;
  logic               w_ch_found;

  // Output register write decode (OUTPUT, plus OUTPUTK when enabled).
  always_comb begin
    w_wr_hit = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (write_strobe && (port_id == out_id(k))) begin
        w_wr_hit[k] = 1'b1;
      end
`ifdef K_WRITE_EN
      else if (k_write_strobe && k_reachable(k) && (port_id[3:0] == out_nib(k))) begin
        w_wr_hit[k] = 1'b1;
      end
`endif
      else begin
        w_wr_hit[k] = 1'b0;
      end
    end
  end

  // Output registers and their one-cycle update flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out      <= {N_OUT{OUT_RST}};
      r_wr_pulse <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (w_wr_hit[k]) begin
          r_out[8*k +: 8] <= out_port;
        end
      end
      r_wr_pulse <= w_wr_hit;
    end
  end

  // IRQ register write decode and pending-bit next state.
  always_comb begin
    w_mask_wr = write_strobe && (port_id == IRQ_MASK_ID);
    if (write_strobe && (port_id == IRQ_STAT_ID)) begin
      w_clr_bits = out_port[N_IRQ-1:0];
    end else begin
      w_clr_bits = '0;
    end
    w_edge     = r_sync2 & ~r_prev;
    // The edge term is OR-ed after the clear so a coincident edge wins.
    w_pend_nxt = (r_pending & ~w_clr_bits) | w_edge;
  end

  // Source synchroniser (polarity-normalised, inactive = 0) and edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= irq_src ^ IRQ_ACT_LOW;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Pending, mask and the registered interrupt request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_pending <= w_pend_nxt;
      if (w_mask_wr) begin
        r_mask <= out_port[N_IRQ-1:0];
      end else begin
        r_mask <= r_mask;
      end
      r_irq <= |(r_pending & r_mask);
    end
  end

  // Read mux: IRQ status, IRQ mask, then lowest-index matching channel.
  always_comb begin
    w_pend_pad = 8'h00;
    w_pend_pad[N_IRQ-1:0] = r_pending;
    w_mask_pad = 8'h00;
    w_mask_pad[N_IRQ-1:0] = r_mask;
    w_rd_data  = 8'h00;
    w_rd_sel   = '0;
    w_ch_found = 1'b0;
    if (port_id == IRQ_STAT_ID) begin
      w_rd_data = w_pend_pad;
    end else if (port_id == IRQ_MASK_ID) begin
      w_rd_data = w_mask_pad;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (!w_ch_found && (port_id == IN_IDS[8*i +: 8])) begin
          w_rd_data   = in_data[8*i +: 8];
          w_rd_sel[i] = 1'b1;
          w_ch_found  = 1'b1;
        end else begin
          w_rd_sel[i] = 1'b0;
        end
      end
    end
  end

  // Registered read data (every cycle) and read-acknowledge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_port  <= 8'h00;
      r_rd_pulse <= '0;
    end else begin
      r_in_port <= w_rd_data;
      if (read_strobe) begin
        r_rd_pulse <= w_rd_sel;
      end else begin
        r_rd_pulse <= '0;
      end
    end
  end

  assign out_regs  = r_out;
  assign wr_pulse  = r_wr_pulse;
  assign in_port   = r_in_port;
  assign rd_pulse  = r_rd_pulse;
  assign interrupt = r_irq;

endmodule

// File: tb/tb_picoblaze_port_hub.sv
// Directed self-checking bench for picoblaze_port_hub (default parameters).
module tb_picoblaze_port_hub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  port_id;
  logic [7:0]  out_port;
  logic        write_strobe;
  logic        k_write_strobe;
  logic        read_strobe;
  logic [31:0] in_data;
  logic [7:0]  in_port;
  logic [3:0]  rd_pulse;
  logic [71:0] out_regs;
  logic [8:0]  wr_pulse;
  logic [1:0]  irq_src;
  logic        interrupt;

  int n_cmp = 0;
  int n_err = 0;

  logic [71:0] exp_regs_k;
  logic [8:0]  exp_wr_k;

  picoblaze_port_hub dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .port_id        (port_id),
    .out_port       (out_port),
    .write_strobe   (write_strobe),
    .k_write_strobe (k_write_strobe),
    .read_strobe    (read_strobe),
    .in_data        (in_data),
    .in_port        (in_port),
    .rd_pulse       (rd_pulse),
    .out_regs       (out_regs),
    .wr_pulse       (wr_pulse),
    .irq_src        (irq_src),
    .interrupt      (interrupt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    port_id        = 8'h00;
    out_port       = 8'h00;
    write_strobe   = 1'b0;
    k_write_strobe = 1'b0;
    read_strobe    = 1'b0;
    // ch3 (id15)=44, ch2 (id13)=A5, ch1 (id12)=33, ch0 (id3)=11
    in_data        = 32'h44_A5_33_11;
    irq_src        = 2'b01;            // both sources idle
    #1;
    check("rst_out_regs", 80'(out_regs), 80'h0);
    check("rst_in_port", 80'(in_port), 80'h0);
    check("rst_interrupt", 80'(interrupt), 80'h0);
    check("rst_pulses", 80'({wr_pulse, rd_pulse}), 80'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Write register 0 (id 2)
    port_id = 8'd2; out_port = 8'h66; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    check("wr0_regs", 80'(out_regs), 80'h66);
    check("wr0_pulse", 80'(wr_pulse), 80'h001);
    tick();
    check("wr0_pulse_drop", 80'(wr_pulse), 80'h000);

    // Last register (id 10) then out-of-range id 11
    port_id = 8'd10; out_port = 8'hC3; write_strobe = 1'b1;
    tick();
    check("wr8_regs", 80'(out_regs), 80'hC3_00_00_00_00_00_00_00_66);
    check("wr8_pulse", 80'(wr_pulse), 80'h100);
    port_id = 8'd11; out_port = 8'hFF;
    tick();
    write_strobe = 1'b0;
    check("wr11_ignored", 80'(out_regs), 80'hC3_00_00_00_00_00_00_00_66);
    check("wr11_no_pulse", 80'(wr_pulse), 80'h000);

    // OUTPUTK to id 3 (register 1)
`ifdef K_WRITE_EN
    exp_regs_k = 72'hC3_00_00_00_00_00_00_5A_66;
    exp_wr_k   = 9'h002;
`else
    exp_regs_k = 72'hC3_00_00_00_00_00_00_00_66;
    exp_wr_k   = 9'h000;
`endif
    port_id = 8'h03; out_port = 8'h5A; k_write_strobe = 1'b1;
    tick();
    k_write_strobe = 1'b0;
    check("kwr_regs", 80'(out_regs), 80'(exp_regs_k));
    check("kwr_pulse", 80'(wr_pulse), 80'(exp_wr_k));

    // Reads
    port_id = 8'd13; read_strobe = 1'b1;
    tick();
    check("rd13_data", 80'(in_port), 80'hA5);
    check("rd13_pulse", 80'(rd_pulse), 80'b0100);
    port_id = 8'd12;
    tick();
    check("rd12_data", 80'(in_port), 80'h33);
    check("rd12_pulse", 80'(rd_pulse), 80'b0010);
    port_id = 8'd99;
    tick();
    check("rd99_data", 80'(in_port), 80'h00);
    check("rd99_pulse", 80'(rd_pulse), 80'b0000);
    read_strobe = 1'b0; port_id = 8'd3;
    tick();
    check("rd3_nostrobe_data", 80'(in_port), 80'h11);
    check("rd3_nostrobe_pulse", 80'(rd_pulse), 80'b0000);

    // Mask = 01, read back
    port_id = 8'd21; out_port = 8'h01; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    tick();
    check("mask_readback", 80'(in_port), 80'h01);

    // Source 0 (active-low) falls; pending after 3 edges, interrupt one later
    port_id = 8'd20;
    irq_src = 2'b00;
    tick();
    tick();
    check("irq0_e2_int", 80'(interrupt), 80'h0);
    tick();
    check("irq0_e3_int", 80'(interrupt), 80'h0);
    check("irq0_e3_stat", 80'(in_port), 80'h00);
    tick();
    check("irq0_e4_stat", 80'(in_port), 80'h01);
    check("irq0_e4_int", 80'(interrupt), 80'h1);

    // W1C bit 0
    out_port = 8'h01; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    tick();
    check("clr_int", 80'(interrupt), 80'h0);
    check("clr_stat", 80'(in_port), 80'h00);
    // Held-active source does not re-trigger
    tick(); tick(); tick(); tick();
    check("held_stat", 80'(in_port), 80'h00);
    check("held_int", 80'(interrupt), 80'h0);

    // Source 1 rises; W1C of bit 1 lands on the same edge as the set
    irq_src = 2'b11;
    tick();
    tick();
    out_port = 8'h02; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    tick();
    check("coll_stat", 80'(in_port), 80'h02);
    check("coll_int_masked", 80'(interrupt), 80'h0);
    tick();
    check("coll_int_masked2", 80'(interrupt), 80'h0);

    // Unmask source 1 -> interrupt
    port_id = 8'd21; out_port = 8'h03; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0; port_id = 8'd20;
    tick();
    check("unmask_int", 80'(interrupt), 80'h1);

    // Write burst, then asynchronous reset mid-burst
    write_strobe = 1'b1;
    port_id = 8'd4; out_port = 8'h77;
    tick();
    port_id = 8'd3; out_port = 8'h88;
    tick();
    check("burst_regs", 80'(out_regs), 80'hC3_00_00_00_00_00_77_88_66);
    check("burst_in_port", 80'(in_port), 80'h11);
    port_id = 8'd5; out_port = 8'h99;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_regs", 80'(out_regs), 80'h0);
    check("arst_interrupt", 80'(interrupt), 80'h0);
    check("arst_in_port", 80'(in_port), 80'h0);
    check("arst_pulses", 80'({wr_pulse, rd_pulse}), 80'h0);
    write_strobe = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
